frame_deserializer: RTL and testbench
=====================================

# frame_deserializer

Receive-side counterpart of the four-phase accumulator sequencer: it accepts a stream of data words one beat at a time, steers each into one of four slot registers in phase order (slot 0 → 1 → 2 → 3), and presents the completed four-word frame as one wide word. It sits between a serial producer (bus, shift path, or the accumulator output) and frame-wide consumers. Ready/valid handshakes are used on both sides, and an optional frame-start marker allows realignment.

## Interface
- `W`, default 8: width of one data word.
- `clk`, input, 1: single rising-edge clock.
- `Reset`, input, 1: synchronous, active-high reset.
- `inValid`, input, 1: producer presents `inData`.
- `inData`, input, W: data word.
- `inFirst`, input, 1: marks the accepted word as slot 0 of a new frame.
- `inReady`, output, 1: block can accept a word this cycle.
- `outValid`, output, 1: `outFrame` holds a complete frame.
- `outFrame`, output, 4*W: `{slot3, slot2, slot1, slot0}`; slot 0 occupies the LSBs.
- `outReady`, input, 1: consumer takes the frame.
- `slotSel`, output, 2: current fill phase (00/01/10/11), registered.
- `alignErr`, output, 1: one-cycle pulse when a frame is aborted by `inFirst`.

## Operation
- **Accept rule:** a word is accepted when `inValid && inReady`. A non-accepted cycle changes no state except the output-side handshake.
- **FSM states:** FILL0, FILL1, FILL2, FILL3, encoded 00–11. The state drives `slotSel` directly.
- **Normal advance:** an accepted word in FILLn writes slot n, then FILLn → FILL(n+1). FILL3 wraps to FILL0.
- **inReady:** `!(state==FILL3 && outValid && !outReady)`. The block stalls only when the 4th word has no place to go.
- **Frame completion:** an accepted word in FILL3 loads `outFrame <= {inData, slot2, slot1, slot0}`, sets `outValid`, and moves to FILL0.
- **Output handshake:** when `outValid && outReady`, clear `outValid` unless a new frame completes in the same cycle. If it does, `outValid` stays 1 and the new frame loads (back-to-back, no bubble).
- **Resync:** if `inFirst` is set on an accepted word:
  - The word goes to slot 0 and the FSM moves to FILL1.
  - If the prior state was not FILL0, the partial frame is discarded and `alignErr` pulses on the next cycle.
  - `inFirst` in FILL0 is legal and silent.
- **Resync in FILL3:** `inFirst` on an accepted FILL3 word means resync, not completion. No frame is emitted.
- **Partial-frame data:** slot registers 0–2 are not cleared on frame completion. Only `outFrame` is architecturally visible.

## Timing
- **Reset values:**
  - state FILL0; `slotSel` 00; `outValid` 0; `outFrame` all zeros; slot registers zero; `alignErr` 0.
  - `inReady` is 1 in the first cycle after reset.
- **Latency:** the 4th word is accepted at edge k; `outValid`/`outFrame` are valid after edge k (visible in cycle k+1).
- **Throughput:** sustains 1 word/cycle. One frame every 4 cycles with `outReady` held high.
- **Stall:** `inReady` depends combinationally on `outReady` (one gate level); there is no combinational path from `inValid`. `outFrame` is held stable while `outValid && !outReady`.
- **Reset mid-frame:** the partial frame and any pending `outFrame` are dropped, with no `alignErr`. `Reset` overrides all simultaneous handshakes.
- **alignErr:** a registered pulse, exactly one cycle per abort. Consecutive aborts give consecutive pulses.

## Structure
- **Shared package `frame_pkg`:**
  - enum `fill_state_t` (FILL0–FILL3, 2-bit, same encoding as the accumulator mux phases).
  - `localparam SLOTS = 4`.
  - typedef `frame_t` as a packed array `[SLOTS-1:0][W-1:0]`.
- **Sub-module `deser_phase_fsm`:** state register, next-state logic, and the `alignErr` flag. Inputs are accept, `inFirst`, and Reset; outputs are state and completion. The datapath (slot registers, output register, handshake) stays in `frame_deserializer`.

## Test plan
- Reset, then feed A1, B2, C3, D4 (W=8) with `outReady`=1: `outFrame`=0xD4C3B2A1, `outValid`=1 for exactly one cycle, `slotSel` sequence 0,1,2,3,0.
- Continuous stream of 8 words with `outReady`=1: two frames on consecutive 4-cycle boundaries, `inReady` constant 1.
- `outReady`=0 after the first frame, keep feeding 4 more words: `inReady` drops in FILL3 and `outFrame` is held. Raising `outReady` gives back-to-back delivery of frame 2 in the next cycle.
- Feed 11, 22, then 33 with `inFirst`=1, then 44, 55, 66: `alignErr` pulses once and `outFrame`=0x66554433.
- Assert `Reset` in FILL2 while `outValid`=1: next cycle `outValid`=0, `slotSel`=00, `outFrame`=0, and no frame is emitted from the partial words.
- `inFirst`=1 on the first word after reset: no `alignErr`, and the frame completes normally.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared types for the frame deserializer: fill-phase encoding and the frame layout.
package frame_pkg;

    localparam int unsigned SLOTS = 4;
    localparam int unsigned WordW = 8;

    // Same encoding as the accumulator mux phases.
    typedef enum logic [1:0] {
        FILL0 = 2'b00,
        FILL1 = 2'b01,
        FILL2 = 2'b10,
        FILL3 = 2'b11
    } fill_state_t;

    typedef logic [SLOTS-1:0][WordW-1:0] frame_t;

    function automatic fill_state_t next_fill(input fill_state_t s);
        return fill_state_t'(s + 2'd1);
    endfunction

endpackage

// File: rtl/frame_deserializer_if.sv
// Producer/consumer handshake bundle for the frame deserializer.
interface frame_deserializer_if #(
    parameter int unsigned W = 8
);
    logic                         inValid;
    logic [W-1:0]                 inData;
    logic                         inFirst;
    logic                         inReady;
    logic                         outValid;
    logic [frame_pkg::SLOTS*W-1:0] outFrame;
    logic                         outReady;
    logic [1:0]                   slotSel;
    logic                         alignErr;

    modport slave (
        input  inValid, inData, inFirst, outReady,
        output inReady, outValid, outFrame, slotSel, alignErr
    );

    modport master (
        output inValid, inData, inFirst, outReady,
        input  inReady, outValid, outFrame, slotSel, alignErr
    );
endinterface

// File: rtl/deser_phase_fsm.sv
// Fill-phase sequencer: tracks which slot the next word lands in and flags aborted frames.
module deser_phase_fsm
    import frame_pkg::*;
(
    input  logic        clk,
    input  logic        Reset,
    input  logic        accept_i,
    input  logic        first_i,
    output fill_state_t state_o,
    output logic        complete_o,
    output logic        align_err_o
);

    fill_state_t state_q, state_d;
    logic        align_err_q, align_err_d;

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q     <= FILL0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            align_err_q <= align_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        align_err_d = 1'b0;
        if (accept_i) begin
            if (first_i) begin
                // Marker restarts the frame; anything already collected is abandoned.
                state_d     = FILL1;
                align_err_d = (state_q != FILL0);
            end else begin
                state_d = next_fill(state_q);
            end
        end
    end

    always_comb begin
        state_o     = state_q;
        complete_o  = accept_i && !first_i && (state_q == FILL3);
        align_err_o = align_err_q;
    end

endmodule

// File: rtl/frame_deserializer.sv
// Collects four serial words into slot registers and presents them as one wide frame.
module frame_deserializer
    import frame_pkg::*;
#(
    parameter int unsigned W = WordW
) (
    input logic                  clk,
    input logic                  Reset,
    frame_deserializer_if.slave  bus
);

    fill_state_t state;
    logic        accept;
    logic        complete;
    logic        align_err;
    logic        in_ready;
    logic [1:0]  wr_idx;

    logic [SLOTS-2:0][W-1:0] slot_q, slot_d;
    logic [SLOTS-1:0][W-1:0] frame_q, frame_d;
    logic                    out_valid_q, out_valid_d;

    deser_phase_fsm u_fsm (
        .clk         (clk),
        .Reset       (Reset),
        .accept_i    (accept),
        .first_i     (bus.inFirst),
        .state_o     (state),
        .complete_o  (complete),
        .align_err_o (align_err)
    );

    always_comb begin
        // Stall only when the closing word has nowhere to go.
        in_ready = !((state == FILL3) && out_valid_q && !bus.outReady);
        accept   = bus.inValid && in_ready;
        wr_idx   = bus.inFirst ? 2'd0 : state;
    end

    always_comb begin
        slot_d      = slot_q;
        frame_d     = frame_q;
        out_valid_d = out_valid_q;
        for (int i = 0; i < SLOTS - 1; i++) begin
            if (accept && !complete && (wr_idx == i[1:0])) begin
                slot_d[i] = bus.inData;
            end
        end
        if (out_valid_q && bus.outReady) begin
            out_valid_d = 1'b0;
        end
        if (complete) begin
            frame_d[SLOTS-2:0]  = slot_q;
            frame_d[SLOTS-1]    = bus.inData;
            out_valid_d         = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            slot_q      <= '0;
            frame_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            frame_q     <= frame_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        bus.inReady  = in_ready;
        bus.outValid = out_valid_q;
        bus.outFrame = frame_q;
        bus.slotSel  = state;
        bus.alignErr = align_err;
    end

endmodule

// File: tb/tb_frame_deserializer.sv
// Directed bench for frame_deserializer with a queue-based frame scoreboard.
module tb_frame_deserializer;

    logic clk = 1'b0;
    logic Reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] exp_q[$];

    frame_deserializer_if #(.W(8)) bus ();

    frame_deserializer #(.W(8)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change just after a rising edge; outputs are looked at on the falling edge.
    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic f, input logic [1:0] sel, input int rdy);
        int waits;
        waits = 0;
        bus.inValid = 1'b1;
        bus.inData  = d;
        bus.inFirst = f;
        @(negedge clk);
        chk("slot_sel", {30'd0, bus.slotSel}, {30'd0, sel});
        if (rdy >= 0) chk("in_ready", {31'd0, bus.inReady}, rdy[31:0]);
        while (!bus.inReady && waits < 50) begin
            nxt();
            @(negedge clk);
            waits++;
        end
        if (waits >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
        nxt();
        bus.inValid = 1'b0;
        bus.inFirst = 1'b0;
    endtask

    // Scoreboard: every delivered frame must match the oldest expected one.
    always @(negedge clk) begin
        if (!Reset && bus.outValid && bus.outReady) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_frame", bus.outFrame, 32'hxxxx_xxxx);
            end else begin
                chk("frame", bus.outFrame, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.inValid  = 1'b0;
        bus.inData   = '0;
        bus.inFirst  = 1'b0;
        bus.outReady = 1'b1;
        repeat (3) @(posedge clk);
        #1 Reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_slot_sel", {30'd0, bus.slotSel}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.outValid}, 32'd0);
        chk("rst_out_frame", bus.outFrame, 32'd0);
        chk("rst_align_err", {31'd0, bus.alignErr}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.inReady}, 32'd1);
        nxt();

        // Single frame
        send(8'hA1, 1'b0, 2'd0, 1);
        send(8'hB2, 1'b0, 2'd1, 1);
        send(8'hC3, 1'b0, 2'd2, 1);
        exp_q.push_back(32'hD4C3B2A1);
        send(8'hD4, 1'b0, 2'd3, 1);
        @(negedge clk);
        chk("t1_out_valid", {31'd0, bus.outValid}, 32'd1);
        chk("t1_slot_wrap", {30'd0, bus.slotSel}, 32'd0);
        nxt();
        @(negedge clk);
        chk("t1_out_valid_drop", {31'd0, bus.outValid}, 32'd0);
        nxt();

        // Continuous stream of two frames
        for (int i = 1; i <= 8; i++) begin
            if (i == 4) exp_q.push_back(32'h04030201);
            if (i == 8) exp_q.push_back(32'h08070605);
            send(i[7:0], 1'b0, 2'((i - 1) % 4), 1);
        end
        @(negedge clk);
        chk("t2_out_valid", {31'd0, bus.outValid}, 32'd1);
        nxt();

        // Back-pressure then back-to-back delivery
        bus.outReady = 1'b0;
        send(8'h10, 1'b0, 2'd0, 1);
        send(8'h20, 1'b0, 2'd1, 1);
        send(8'h30, 1'b0, 2'd2, 1);
        exp_q.push_back(32'h40302010);
        send(8'h40, 1'b0, 2'd3, 1);
        send(8'h50, 1'b0, 2'd0, 1);
        send(8'h60, 1'b0, 2'd1, 1);
        send(8'h70, 1'b0, 2'd2, 1);
        exp_q.push_back(32'h80706050);
        bus.inValid = 1'b1;
        bus.inData  = 8'h80;
        @(negedge clk);
        chk("t3_stall_ready", {31'd0, bus.inReady}, 32'd0);
        chk("t3_stall_sel", {30'd0, bus.slotSel}, 32'd3);
        chk("t3_hold_frame", bus.outFrame, 32'h40302010);
        nxt();
        @(negedge clk);
        chk("t3_stall_ready2", {31'd0, bus.inReady}, 32'd0);
        chk("t3_hold_frame2", bus.outFrame, 32'h40302010);
        nxt();
        bus.outReady = 1'b1;
        @(negedge clk);
        chk("t3_ready_release", {31'd0, bus.inReady}, 32'd1);
        nxt();
        bus.inValid = 1'b0;
        @(negedge clk);
        chk("t3_b2b_valid", {31'd0, bus.outValid}, 32'd1);
        chk("t3_b2b_frame", bus.outFrame, 32'h80706050);
        nxt();

        // Resync with inFirst mid-frame
        send(8'h11, 1'b0, 2'd0, 1);
        send(8'h22, 1'b0, 2'd1, 1);
        send(8'h33, 1'b1, 2'd2, 1);
        @(negedge clk);
        chk("t4_align_err", {31'd0, bus.alignErr}, 32'd1);
        chk("t4_resync_sel", {30'd0, bus.slotSel}, 32'd1);
        nxt();
        @(negedge clk);
        chk("t4_align_err_pulse", {31'd0, bus.alignErr}, 32'd0);
        nxt();
        send(8'h44, 1'b0, 2'd1, 1);
        send(8'h55, 1'b0, 2'd2, 1);
        exp_q.push_back(32'h66554433);
        send(8'h66, 1'b0, 2'd3, 1);
        @(negedge clk);
        chk("t4_out_valid", {31'd0, bus.outValid}, 32'd1);
        chk("t4_no_err", {31'd0, bus.alignErr}, 32'd0);
        nxt();

        // Reset in FILL2 with a frame pending
        bus.outReady = 1'b0;
        send(8'h70, 1'b0, 2'd0, 1);
        send(8'h71, 1'b0, 2'd1, 1);
        send(8'h72, 1'b0, 2'd2, 1);
        send(8'h73, 1'b0, 2'd3, 1);
        send(8'h74, 1'b0, 2'd0, 1);
        send(8'h75, 1'b0, 2'd1, 1);
        @(negedge clk);
        chk("t5_pre_sel", {30'd0, bus.slotSel}, 32'd2);
        chk("t5_pre_valid", {31'd0, bus.outValid}, 32'd1);
        nxt();
        Reset       = 1'b1;
        bus.inValid = 1'b1;
        bus.inData  = 8'h99;
        nxt();
        Reset        = 1'b0;
        bus.inValid  = 1'b0;
        bus.outReady = 1'b1;
        @(negedge clk);
        chk("t5_out_valid", {31'd0, bus.outValid}, 32'd0);
        chk("t5_slot_sel", {30'd0, bus.slotSel}, 32'd0);
        chk("t5_out_frame", bus.outFrame, 32'd0);
        chk("t5_align_err", {31'd0, bus.alignErr}, 32'd0);
        nxt();
        send(8'h76, 1'b0, 2'd0, 1);
        send(8'h77, 1'b0, 2'd1, 1);
        @(negedge clk);
        chk("t5_no_frame", {31'd0, bus.outValid}, 32'd0);
        nxt();

        // inFirst on the first word after reset
        Reset = 1'b1;
        nxt();
        Reset = 1'b0;
        exp_q.push_back(32'hE4E3E2E1);
        send(8'hE1, 1'b1, 2'd0, 1);
        @(negedge clk);
        chk("t6_silent_first", {31'd0, bus.alignErr}, 32'd0);
        nxt();
        send(8'hE2, 1'b0, 2'd1, 1);
        send(8'hE3, 1'b0, 2'd2, 1);
        send(8'hE4, 1'b0, 2'd3, 1);
        @(negedge clk);
        chk("t6_out_valid", {31'd0, bus.outValid}, 32'd1);
        chk("t6_align_err", {31'd0, bus.alignErr}, 32'd0);
        nxt();

        repeat (3) nxt();
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
